// File: rtl/cpu_bus_bridge_if.sv
// rtl/cpu_bus_bridge_if.sv - pin-side and memory-side signal bundle of the 6502 bus bridge
interface cpu_bus_bridge_if;
  logic        phase;
  logic [7:0]  cpu_ab_byte;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_doe;
  logic [7:0]  cpu_din;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_req;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        busy;
  logic        timeout_err;
  logic        overrun_err;
  logic        trace_valid;
  logic [24:0] trace_word;

  modport master (
    input  phase, cpu_ab_byte, cpu_dout, cpu_doe, mem_ack, mem_rdata,
    output cpu_din, mem_addr, mem_wdata, mem_we, mem_req,
    output busy, timeout_err, overrun_err, trace_valid, trace_word
  );

  modport slave (
    output phase, cpu_ab_byte, cpu_dout, cpu_doe, mem_ack, mem_rdata,
    input  cpu_din, mem_addr, mem_wdata, mem_we, mem_req,
    input  busy, timeout_err, overrun_err, trace_valid, trace_word
  );
endinterface

// File: rtl/cpu_bus_bridge.sv
// rtl/cpu_bus_bridge.sv - 6502 phase-multiplexed pins to req/ack memory port, one-deep pending buffer
// Optional completion trace enabled by defining BRIDGE_TRACE_EN.
module cpu_bus_bridge #(
  parameter int unsigned WAIT_MAX     = 16,
  parameter logic [7:0]  TIMEOUT_DATA = 8'hFF
) (
  input logic              clk,
  input logic              rst_n,
  cpu_bus_bridge_if.master bus
);
  localparam int unsigned   CW        = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_LAST = (WAIT_MAX == 0) ? '0 : CW'(WAIT_MAX - 1);

  typedef enum logic {ST_IDLE, ST_REQ} state_e;

  state_e        state_q, state_d;
  logic [7:0]    hi_q, hi_d, wd_q, wd_d;
  logic          hi_vld_q, hi_vld_d;
  logic          pend_vld_q, pend_vld_d, pend_rw_q, pend_rw_d;
  logic [15:0]   pend_addr_q, pend_addr_d;
  logic [7:0]    pend_wd_q, pend_wd_d;
  logic [15:0]   addr_q, addr_d;
  logic          we_q, we_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    din_q, din_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          to_err_q, to_err_d, ov_err_q, ov_err_d;

  logic          txn_new, txn_rw, abort, done;
  logic [15:0]   txn_addr;
  logic [7:0]    rd_data;
  logic          unused_doe;

  // cpu_doe carries no decode information; rw is taken from cpu_dout[0] only.
  assign unused_doe = ^bus.cpu_doe;

  assign txn_new  = !bus.phase && hi_vld_q;
  assign txn_rw   = bus.cpu_dout[0];
  assign txn_addr = {hi_q, bus.cpu_ab_byte};
  assign abort    = (state_q == ST_REQ) && !bus.mem_ack && (WAIT_MAX != 0) && (wait_q == WAIT_LAST);
  assign done     = (state_q == ST_REQ) && (bus.mem_ack || abort);
  assign rd_data  = bus.mem_ack ? bus.mem_rdata : TIMEOUT_DATA;

  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    wd_d        = wd_q;
    hi_vld_d    = hi_vld_q;
    pend_vld_d  = pend_vld_q;
    pend_rw_d   = pend_rw_q;
    pend_addr_d = pend_addr_q;
    pend_wd_d   = pend_wd_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    din_d       = din_q;
    wait_d      = wait_q;
    to_err_d    = to_err_q;
    ov_err_d    = ov_err_q;

    if (bus.phase) begin
      hi_d     = bus.cpu_ab_byte;
      wd_d     = bus.cpu_dout;
      hi_vld_d = 1'b1;
    end else if (hi_vld_q) begin
      hi_vld_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (txn_new) begin
          addr_d  = txn_addr;
          we_d    = ~txn_rw;
          wdata_d = wd_q;
          wait_d  = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (done) begin
          if (!we_q) din_d = rd_data;
          if (abort) to_err_d = 1'b1;
          if (pend_vld_q) begin
            addr_d     = pend_addr_q;
            we_d       = ~pend_rw_q;
            wdata_d    = pend_wd_q;
            wait_d     = '0;
            pend_vld_d = 1'b0;
            if (txn_new) ov_err_d = 1'b1;
          end else if (txn_new) begin
            // Pending is free, so a txn landing on the completion cycle follows straight on.
            addr_d  = txn_addr;
            we_d    = ~txn_rw;
            wdata_d = wd_q;
            wait_d  = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          wait_d = wait_q + 1'b1;
          if (txn_new) begin
            if (pend_vld_q) begin
              ov_err_d = 1'b1;
            end else begin
              pend_vld_d  = 1'b1;
              pend_rw_d   = txn_rw;
              pend_addr_d = txn_addr;
              pend_wd_d   = wd_q;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hi_q        <= '0;
      wd_q        <= '0;
      hi_vld_q    <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_rw_q   <= 1'b0;
      pend_addr_q <= '0;
      pend_wd_q   <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      din_q       <= '0;
      wait_q      <= '0;
      to_err_q    <= 1'b0;
      ov_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      wd_q        <= wd_d;
      hi_vld_q    <= hi_vld_d;
      pend_vld_q  <= pend_vld_d;
      pend_rw_q   <= pend_rw_d;
      pend_addr_q <= pend_addr_d;
      pend_wd_q   <= pend_wd_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      din_q       <= din_d;
      wait_q      <= wait_d;
      to_err_q    <= to_err_d;
      ov_err_q    <= ov_err_d;
    end
  end

  assign bus.mem_req     = (state_q == ST_REQ);
  assign bus.mem_addr    = addr_q;
  assign bus.mem_we      = we_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.cpu_din     = din_q;
  assign bus.busy        = (state_q == ST_REQ) || pend_vld_q;
  assign bus.timeout_err = to_err_q;
  assign bus.overrun_err = ov_err_q;

`ifdef BRIDGE_TRACE_EN
  logic        trace_valid_q;
  logic [24:0] trace_word_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trace_valid_q <= 1'b0;
      trace_word_q  <= '0;
    end else begin
      trace_valid_q <= done;
      if (done) trace_word_q <= {~we_q, addr_q, we_q ? wdata_q : rd_data};
    end
  end

  assign bus.trace_valid = trace_valid_q;
  assign bus.trace_word  = trace_word_q;
`else
  assign bus.trace_valid = 1'b0;
  assign bus.trace_word  = '0;
`endif
endmodule

// File: tb/tb_cpu_bus_bridge.sv
// tb/tb_cpu_bus_bridge.sv - scoreboard bench for cpu_bus_bridge (main instance plus a WAIT_MAX=4 instance)
module tb_cpu_bus_bridge;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  logic [24:0] sb_q[$];
  logic prev_req = 1'b0;
  logic prev_ack = 1'b0;

  always #5 clk = ~clk;

  cpu_bus_bridge_if ifa ();
  cpu_bus_bridge_if ifb ();

  cpu_bus_bridge dut (.clk(clk), .rst_n(rst_n), .bus(ifa.master));
  cpu_bus_bridge #(.WAIT_MAX(4), .TIMEOUT_DATA(8'hFF)) dut_to (.clk(clk), .rst_n(rst_n), .bus(ifb.master));

  assign ifb.phase       = ifa.phase;
  assign ifb.cpu_ab_byte = ifa.cpu_ab_byte;
  assign ifb.cpu_dout    = ifa.cpu_dout;
  assign ifb.cpu_doe     = ifa.cpu_doe;
  assign ifb.mem_ack     = ifa.mem_ack;
  assign ifb.mem_rdata   = ifa.mem_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_txn(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] wd,
                         input logic rw, input logic push);
    ifa.phase = 1'b1; ifa.cpu_ab_byte = hi; ifa.cpu_dout = wd; ifa.cpu_doe = 8'hFF;
    tick();
    ifa.phase = 1'b0; ifa.cpu_ab_byte = lo; ifa.cpu_dout = {7'b1010101, rw}; ifa.cpu_doe = 8'h00;
    if (push) sb_q.push_back({~rw, hi, lo, wd});
    tick();
  endtask

  task automatic ack(input logic [7:0] rd);
    ifa.mem_ack = 1'b1; ifa.mem_rdata = rd;
    tick();
    ifa.mem_ack = 1'b0; ifa.mem_rdata = 8'h00;
  endtask

  // Every new issue on the main memory port is matched against the oldest expected transaction.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      prev_req = 1'b0;
      prev_ack = 1'b0;
    end else begin
      if (ifa.mem_req && (!prev_req || prev_ack)) begin
        if (sb_q.size() == 0) check("issue_unexpected", {ifa.mem_we, ifa.mem_addr, ifa.mem_wdata}, 32'hFFFFFFFF);
        else check("issue", {ifa.mem_we, ifa.mem_addr, ifa.mem_wdata}, sb_q.pop_front());
      end
      prev_req = ifa.mem_req;
      prev_ack = ifa.mem_ack;
    end
  end

  initial begin
    ifa.phase = 1'b0; ifa.cpu_ab_byte = 8'h00; ifa.cpu_dout = 8'h00; ifa.cpu_doe = 8'h00;
    ifa.mem_ack = 1'b0; ifa.mem_rdata = 8'h00;
    tick(); tick();
    check("rst_req",   ifa.mem_req, 0);
    check("rst_we",    ifa.mem_we, 0);
    check("rst_addr",  ifa.mem_addr, 0);
    check("rst_wdata", ifa.mem_wdata, 0);
    check("rst_din",   ifa.cpu_din, 0);
    check("rst_flags", {ifa.busy, ifa.timeout_err, ifa.overrun_err, ifa.trace_valid}, 0);
    check("rst_trace", ifa.trace_word, 0);
    rst_n = 1'b1;

    // Read of 16'h1234, acked on the second request cycle.
    cpu_txn(8'h12, 8'h34, 8'h00, 1'b1, 1'b1);
    check("rd_req", {ifa.mem_req, ifa.mem_we, ifa.busy}, 3'b101);
    check("rd_addr", ifa.mem_addr, 16'h1234);
    tick();
    ack(8'hA5);
    check("rd_din", ifa.cpu_din, 8'hA5);
    check("rd_idle", {ifa.mem_req, ifa.busy}, 2'b00);

    // Write of 8'h5A to 16'hC001 leaves cpu_din alone.
    cpu_txn(8'hC0, 8'h01, 8'h5A, 1'b0, 1'b1);
    check("wr_bus", {ifa.mem_we, ifa.mem_addr, ifa.mem_wdata}, {1'b1, 16'hC001, 8'h5A});
    ack(8'h3C);
    check("wr_din", ifa.cpu_din, 8'hA5);
    check("wr_idle", ifa.mem_req, 0);

    // Back-to-back: second read pends, third is dropped.
    cpu_txn(8'h01, 8'h00, 8'h00, 1'b1, 1'b1);
    cpu_txn(8'h02, 8'h00, 8'h00, 1'b1, 1'b1);
    check("pend_hold", ifa.mem_addr, 16'h0100);
    check("pend_ov0", ifa.overrun_err, 0);
    cpu_txn(8'h03, 8'h00, 8'h00, 1'b1, 1'b0);
    check("pend_ov1", ifa.overrun_err, 1);
    ack(8'h11);
    check("pend_issue", {ifa.mem_req, ifa.mem_addr}, {1'b1, 16'h0200});
    check("pend_din1", ifa.cpu_din, 8'h11);
    ack(8'h22);
    check("pend_din2", ifa.cpu_din, 8'h22);
    check("pend_idle", {ifa.mem_req, ifa.busy}, 2'b00);

    // Write 8'h77 to 16'h00FF and look at the trace port.
    cpu_txn(8'h00, 8'hFF, 8'h77, 1'b0, 1'b1);
    ack(8'h99);
`ifdef BRIDGE_TRACE_EN
    check("trace_vld", ifa.trace_valid, 1);
    check("trace_word", ifa.trace_word, {1'b0, 16'h00FF, 8'h77});
    tick();
    check("trace_pulse", ifa.trace_valid, 0);
`else
    check("trace_off", {ifa.trace_valid, ifa.trace_word}, 0);
`endif

    // Reset while a request is outstanding.
    cpu_txn(8'hAB, 8'hCD, 8'h00, 1'b1, 1'b1);
    check("mid_req", ifa.mem_req, 1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_req", {ifa.mem_req, ifa.busy, ifa.mem_we}, 0);
    check("mid_rst_bus", {ifa.mem_addr, ifa.cpu_din}, 0);
    check("mid_rst_err", {ifa.overrun_err, ifa.timeout_err}, 0);
    rst_n = 1'b1;
    ack(8'h66);
    check("late_ack", {ifa.mem_req, ifa.cpu_din}, 0);

    // Lone phase-0 cycles after reset must not start a request.
    ifa.cpu_ab_byte = 8'h55; ifa.cpu_dout = 8'h01;
    tick(); tick();
    check("lone_phase0", {ifa.mem_req, ifa.busy, ifb.mem_req}, 0);

    // Timeout on the WAIT_MAX=4 instance, read of 16'hFFFF never acked.
    cpu_txn(8'hFF, 8'hFF, 8'h00, 1'b1, 1'b1);
    check("to_issue", {ifb.mem_req, ifb.mem_addr}, {1'b1, 16'hFFFF});
    tick(); tick(); tick();
    check("to_hold", ifb.mem_req, 1);
    tick();
    check("to_abort", {ifb.mem_req, ifb.busy, ifb.timeout_err}, 3'b001);
    check("to_din", ifb.cpu_din, 8'hFF);
    check("to_main_ok", ifa.timeout_err, 0);
    ack(8'h42);
    check("to_late_ack", {ifb.mem_req, ifb.cpu_din}, {1'b0, 8'hFF});
    check("main_din", ifa.cpu_din, 8'h42);
    tick();
    check("sb_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
